regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (rw + ps) between NUM_REQ writeback requesters
//  (e.g. ALU, load unit, multi-cycle units). Round-robin grant, valid/ready per requester,
//  one-cycle registered output stage feeding the regfile writeback interface.
// PARAMETERS
//  NUM_REQ     2            number of requesters (2..4); index 0 wins the first post-reset arbitration
//  DATA_WIDTH  `DATA_WIDTH  register data width
//  ADDR_WIDTH  4            register address width (16 registers)
// PORTS
//  clk            in   1                   clock; all state updates on posedge
//  n_rst          in   1                   reset, synchronous, active-low
//  req_valid      in   NUM_REQ             requester i has a write pending
//  req_ready      out  NUM_REQ             requester i's write accepted this cycle
//  req_use_rw     in   NUM_REQ             requester i writes a data register
//  req_rw_addr    in   NUM_REQ*ADDR_WIDTH  dest register, slice i
//  req_data       in   NUM_REQ*DATA_WIDTH  write data, slice i
//  req_write_ps   in   NUM_REQ             requester i writes the predicate bit
//  req_ps         in   NUM_REQ             predicate value, bit i
//  wb_stall       in   1                   downstream cannot take wb_* this cycle
//  wb_valid       out  1                   registered writeback valid
//  wb_use_rw      out  1                   registered; write regs[wb_rw_addr]
//  wb_rw_addr     out  ADDR_WIDTH          registered dest address
//  wb_data        out  DATA_WIDTH          registered write data
//  wb_write_ps    out  1                   registered; write ps
//  wb_ps          out  1                   registered predicate value
//  wb_grant_id    out  $clog2(NUM_REQ)     index of requester occupying the output stage
// BEHAVIOUR
//  - Reset (n_rst=0 at posedge): all wb_* outputs 0, RR pointer = 0; req_ready is 0 while n_rst=0.
//  - Output stage "free" = ~wb_valid | ~wb_stall. req_ready is combinational: one-hot grant & free.
//  - Arbitration: among asserted req_valid, grant first index at or after RR pointer (wrapping
//    NUM_REQ-1 -> 0). At most one req_ready high per cycle; none when no valid or stage not free.
//  - Transfer: req_valid[i] & req_ready[i]. On transfer, slice i captured into wb_* next posedge,
//    wb_valid=1, wb_grant_id=i, RR pointer <= (i+1) mod NUM_REQ. Latency request->wb_valid = 1 cycle.
//  - No transfer and free: wb_valid <= 0 (other wb_* fields don't-care but hold value); pointer unchanged.
//  - Stall: wb_valid & wb_stall holds every wb_* field and pointer; all req_ready = 0.
//  - Requester must hold valid and payload stable until ready; arbiter never drops a pending valid.
//  - Fairness: a continuously valid requester is granted within NUM_REQ transfers.
//  - Request with use_rw=0 and write_ps=0 is legal: transferred, produces wb_valid with no writes.
//  - Same-address writes from different requesters are serialized in grant order; later one wins.
//  - Reset mid-stall or with pending requests: state cleared, pending requests re-arbitrate from index 0.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined: adds outputs byp_valid (1), byp_addr (ADDR_WIDTH), byp_data (DATA_WIDTH),
//    byp_ps_valid (1), byp_ps (1): combinational copy of the granted requester's payload in the
//    transfer cycle (byp_valid = transfer & use_rw; byp_ps_valid = transfer & write_ps), letting
//    operand reads see the value one cycle early. Outputs 0 when no transfer or in reset.
//  Not defined: ports absent; behaviour otherwise identical.
// TESTING
//  - Reset: hold n_rst=0 2 cycles with req_valid=2'b11 -> req_ready=0, wb_valid=0, all wb_* 0.
//  - Single req: req0 valid addr=3 data=0xA5 use_rw=1 -> ready0 same cycle; next cycle wb_valid=1,
//    wb_rw_addr=3, wb_data=0xA5, wb_grant_id=0; then wb_valid=0.
//  - Contention: req0,req1 both valid continuously 6 cycles -> grants 0,1,0,1,0,1; one ready per cycle.
//  - Stall: wb_valid=1 (addr 5) with wb_stall=1 for 3 cycles, req1 valid -> wb_* held, ready=0;
//    stall drop -> req1 accepted that cycle, appears on wb_* next cycle.
//  - Predicate + collision: req0 addr=7 data=1, req1 addr=7 data=2 write_ps=1 ps=1 together ->
//    two consecutive wb transfers in RR order; final regs[7] equals later grant's data, ps=1.
//  - Bypass (RF_WB_BYPASS_EN): req1 addr=9 data=0x3C -> byp_valid=1, byp_addr=9, byp_data=0x3C
//    in ready cycle; wb_* match one cycle later. Rerun suite without macro: no byp ports, all pass.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port (data register + predicate bit)
// between NUM_REQ writeback requesters. Requesters are served round-robin with
// a valid/ready handshake, and the winner's payload lands in a one-entry
// registered output stage that drives the regfile writeback interface.
//
// Parameters
//   NUM_REQ      number of requesters (2..4); requester 0 wins the first
//                arbitration after reset
//   DATA_WIDTH   register data width (defaults to the `DATA_WIDTH macro)
//   ADDR_WIDTH   register address width
//
// Ports
//   clk            clock, all state updates on the rising edge
//   n_rst          synchronous active-low reset
//   req_valid      per requester: write pending
//   req_ready      per requester: write accepted this cycle (combinational)
//   req_use_rw     per requester: writes a data register
//   req_rw_addr    per requester destination register, slice i
//   req_data       per requester write data, slice i
//   req_write_ps   per requester: writes the predicate bit
//   req_ps         per requester predicate value, bit i
//   wb_stall       downstream cannot take wb_* this cycle
//   wb_valid       registered writeback valid
//   wb_use_rw      registered: write regs[wb_rw_addr]
//   wb_rw_addr     registered destination address
//   wb_data        registered write data
//   wb_write_ps    registered: write the predicate bit
//   wb_ps          registered predicate value
//   wb_grant_id    index of the requester occupying the output stage
//
// Optional feature (macro RF_WB_BYPASS_EN)
//   byp_valid, byp_addr, byp_data, byp_ps_valid, byp_ps: combinational copy
//   of the granted payload in the transfer cycle so operand reads can see the
//   value one cycle before it reaches the regfile. All zero when no transfer.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_use_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_rw_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_write_ps,
  input  logic [NUM_REQ-1:0]              req_ps,
  input  logic                            wb_stall,
  output logic                            wb_valid,
  output logic                            wb_use_rw,
  output logic [ADDR_WIDTH-1:0]           wb_rw_addr,
  output logic [DATA_WIDTH-1:0]           wb_data,
  output logic                            wb_write_ps,
  output logic                            wb_ps,
  output logic [$clog2(NUM_REQ)-1:0]      wb_grant_id
`ifdef RF_WB_BYPASS_EN
  ,
  output logic                            byp_valid,
  output logic [ADDR_WIDTH-1:0]           byp_addr,
  output logic [DATA_WIDTH-1:0]           byp_data,
  output logic                            byp_ps_valid,
  output logic                            byp_ps
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]        rr_ptr_r;
  logic                  grant_found_s;
  logic [IDW-1:0]        grant_idx_s;
  logic [IDW-1:0]        ptr_next_s;
  logic                  free_s;
  logic                  transfer_s;
  logic                  sel_use_rw_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  sel_write_ps_s;
  logic                  sel_ps_s;

  // Requester index reached by stepping 'offset' places from 'base', wrapping
  // at NUM_REQ (which need not be a power of two).
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return IDW'(sum);
  endfunction

  // The stage can take a new entry when it is empty or its entry drains now.
  assign free_s     = ~wb_valid | ~wb_stall;
  // Reset gates the handshake so nothing is accepted while n_rst is low.
  assign transfer_s = n_rst & free_s & grant_found_s;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found_s && req_valid[rr_index(rr_ptr_r, k)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = rr_index(rr_ptr_r, k);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Pointer moves one past the winner so it has lowest priority next time.
  always_comb begin
    if (grant_idx_s == IDW'(NUM_REQ - 1)) begin
      ptr_next_s = {IDW{1'b0}};
    end else begin
      ptr_next_s = grant_idx_s + IDW'(1);
    end
  end

  // One-hot ready toward the granted requester, only when a transfer happens.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (transfer_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Payload multiplexer selecting the granted requester's slice.
  always_comb begin
    sel_use_rw_s   = req_use_rw[grant_idx_s];
    sel_addr_s     = req_rw_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
    sel_data_s     = req_data[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
    sel_write_ps_s = req_write_ps[grant_idx_s];
    sel_ps_s       = req_ps[grant_idx_s];
  end

  // Output stage and round-robin pointer; a stalled entry holds everything.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wb_valid    <= 1'b0;
      wb_use_rw   <= 1'b0;
      wb_rw_addr  <= {ADDR_WIDTH{1'b0}};
      wb_data     <= {DATA_WIDTH{1'b0}};
      wb_write_ps <= 1'b0;
      wb_ps       <= 1'b0;
      wb_grant_id <= {IDW{1'b0}};
      rr_ptr_r    <= {IDW{1'b0}};
    end else if (transfer_s) begin
      wb_valid    <= 1'b1;
      wb_use_rw   <= sel_use_rw_s;
      wb_rw_addr  <= sel_addr_s;
      wb_data     <= sel_data_s;
      wb_write_ps <= sel_write_ps_s;
      wb_ps       <= sel_ps_s;
      wb_grant_id <= grant_idx_s;
      rr_ptr_r    <= ptr_next_s;
    end else if (free_s) begin
      // Entry drained with nothing to replace it; payload fields keep value.
      wb_valid    <= 1'b0;
    end else begin
      wb_valid    <= wb_valid;
    end
  end

`ifdef RF_WB_BYPASS_EN
  // Early copy of the accepted payload for operand forwarding.
  always_comb begin
    if (transfer_s) begin
      byp_valid    = sel_use_rw_s;
      byp_addr     = sel_addr_s;
      byp_data     = sel_data_s;
      byp_ps_valid = sel_write_ps_s;
      byp_ps       = sel_ps_s;
    end else begin
      byp_valid    = 1'b0;
      byp_addr     = {ADDR_WIDTH{1'b0}};
      byp_data     = {DATA_WIDTH{1'b0}};
      byp_ps_valid = 1'b0;
      byp_ps       = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_regfile_wb_arbiter;

  localparam int NR = 2;
  localparam int DW = `DATA_WIDTH;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [NR-1:0]     req_valid, req_ready, req_use_rw, req_write_ps, req_ps;
  logic [NR*AW-1:0]  req_rw_addr;
  logic [NR*DW-1:0]  req_data;
  logic              wb_stall;
  logic              wb_valid, wb_use_rw, wb_write_ps, wb_ps;
  logic [AW-1:0]     wb_rw_addr;
  logic [DW-1:0]     wb_data;
  logic [0:0]        wb_grant_id;
`ifdef RF_WB_BYPASS_EN
  logic              byp_valid, byp_ps_valid, byp_ps;
  logic [AW-1:0]     byp_addr;
  logic [DW-1:0]     byp_data;
`endif

  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_use_rw(req_use_rw),
    .req_rw_addr(req_rw_addr), .req_data(req_data),
    .req_write_ps(req_write_ps), .req_ps(req_ps),
    .wb_stall(wb_stall), .wb_valid(wb_valid), .wb_use_rw(wb_use_rw),
    .wb_rw_addr(wb_rw_addr), .wb_data(wb_data), .wb_write_ps(wb_write_ps),
    .wb_ps(wb_ps), .wb_grant_id(wb_grant_id)
`ifdef RF_WB_BYPASS_EN
    , .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
    .byp_ps_valid(byp_ps_valid), .byp_ps(byp_ps)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // requester agents
  bit          rv   [NR];
  bit          ruse [NR];
  bit          rwps [NR];
  bit          rps  [NR];
  logic [AW-1:0] raddr [NR];
  logic [DW-1:0] rdata [NR];

  // reference model: contents of the writeback stage and next-priority index
  bit          m_valid, m_use, m_wps, m_ps;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int          m_gid, m_ptr;

  logic [NR-1:0] obs_ready;
  int          last_grant;
  logic [DW-1:0] regs_obs [16];
  bit          ps_obs;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0] obs_byp_addr;
  logic [DW-1:0] obs_byp_data;
  bit            obs_byp_valid;
`endif

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]             = rv[i];
      req_use_rw[i]            = ruse[i];
      req_write_ps[i]          = rwps[i];
      req_ps[i]                = rps[i];
      req_rw_addr[i*AW +: AW]  = raddr[i];
      req_data[i*DW +: DW]     = rdata[i];
    end
  endtask

  task automatic new_req(input int i);
    rv[i]    = 1'b1;
    ruse[i]  = $urandom_range(0, 3) != 0;
    rwps[i]  = $urandom_range(0, 1) != 0;
    rps[i]   = $urandom_range(0, 1) != 0;
    raddr[i] = AW'($urandom);
    rdata[i] = DW'({$urandom, $urandom});
  endtask

  // One clock: check ready against the model, advance, check the stage.
  task automatic cycle();
    int g;
    bit free;
    logic [NR-1:0] er;
    drive();
    #2;
    if (wb_valid === 1'b1 && wb_stall === 1'b0) begin
      if (wb_use_rw) regs_obs[wb_rw_addr] = wb_data;
      if (wb_write_ps) ps_obs = wb_ps;
    end
    g = -1;
    free = 1'b0;
    if (n_rst) begin
      free = !m_valid || !wb_stall;
      if (free) begin
        for (int k = 0; k < NR; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        end
      end
    end
    er = (g >= 0) ? NR'(1 << g) : {NR{1'b0}};
    obs_ready = req_ready;
    last_grant = g;
    n_cmp++;
    if (req_ready !== er) begin
      n_bad++;
      $display("FAIL ready t=%0t: got %b want %b", $time, req_ready, er);
    end
`ifdef RF_WB_BYPASS_EN
    begin
      logic [AW+DW+3-1:0] eb, ob;
      if (g >= 0)
        eb = {req_use_rw[g], req_rw_addr[g*AW +: AW], req_data[g*DW +: DW], req_write_ps[g], req_ps[g]};
      else
        eb = {(AW+DW+3){1'b0}};
      ob = {byp_valid, byp_addr, byp_data, byp_ps_valid, byp_ps};
      obs_byp_valid = byp_valid;
      obs_byp_addr  = byp_addr;
      obs_byp_data  = byp_data;
      n_cmp++;
      if (ob !== eb) begin
        n_bad++;
        $display("FAIL bypass t=%0t: got %h want %h", $time, ob, eb);
      end
    end
`endif
    @(posedge clk);
    if (!n_rst) begin
      m_valid = 0; m_use = 0; m_wps = 0; m_ps = 0; m_addr = '0; m_data = '0; m_gid = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_use   = req_use_rw[g];
      m_addr  = req_rw_addr[g*AW +: AW];
      m_data  = req_data[g*DW +: DW];
      m_wps   = req_write_ps[g];
      m_ps    = req_ps[g];
      m_gid   = g;
      m_ptr   = (g + 1) % NR;
    end else if (free) begin
      m_valid = 0;
    end
    #1;
    n_cmp++;
    if (wb_valid !== m_valid) begin
      n_bad++;
      $display("FAIL wb_valid t=%0t: got %b want %b", $time, wb_valid, m_valid);
    end
    n_cmp++;
    if ({wb_use_rw, wb_rw_addr, wb_data, wb_write_ps, wb_ps, wb_grant_id} !==
        {m_use, m_addr, m_data, m_wps, m_ps, 1'(m_gid)}) begin
      n_bad++;
      $display("FAIL wb_fields t=%0t: got use=%b a=%h d=%h wps=%b ps=%b id=%0d want use=%b a=%h d=%h wps=%b ps=%b id=%0d",
               $time, wb_use_rw, wb_rw_addr, wb_data, wb_write_ps, wb_ps, wb_grant_id,
               m_use, m_addr, m_data, m_wps, m_ps, m_gid);
    end
  endtask

  // Requesters drop a request once it has been accepted.
  task automatic retire();
    for (int i = 0; i < NR; i++) if (rv[i] && obs_ready[i]) rv[i] = 1'b0;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) begin
      rv[i] = 0; ruse[i] = 0; rwps[i] = 0; rps[i] = 0; raddr[i] = '0; rdata[i] = '0;
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    cycle();
    cycle();
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; wb_stall = 1'b0;
    idle_all();
    rv[0] = 1; rv[1] = 1;
    cycle();
    cycle();
    n_cmp++;
    if ({wb_valid, wb_use_rw, wb_rw_addr, wb_data, wb_write_ps, wb_ps, wb_grant_id} !== '0 || obs_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b data=%h ready=%b want all zero", wb_valid, wb_data, obs_ready);
    end
    idle_all();
    n_rst = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    do_reset();
    idle_all();
    rv[0] = 1; ruse[0] = 1; raddr[0] = 4'd3; rdata[0] = DW'(8'hA5);
    cycle();
    n_cmp++;
    if (obs_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b want 01", obs_ready); end
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_rw_addr !== 4'd3 || wb_data !== DW'(8'hA5) || wb_grant_id !== 1'b0) begin
      n_bad++;
      $display("FAIL single_wb: got v=%b a=%h d=%h id=%0d want v=1 a=3 d=a5 id=0", wb_valid, wb_rw_addr, wb_data, wb_grant_id);
    end
    retire();
    cycle();
    n_cmp++;
    if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %b want 0", wb_valid); end
  endtask

  task automatic test_contention();
    do_reset();
    new_req(0); new_req(1);
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_cmp++;
      if (obs_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL contention_%0d: got %b want %b", k, obs_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      for (int i = 0; i < NR; i++) if (obs_ready[i]) new_req(i);
    end
    idle_all();
    cycle();
  endtask

  task automatic test_stall();
    do_reset();
    idle_all();
    rv[0] = 1; ruse[0] = 1; raddr[0] = 4'd5; rdata[0] = DW'($urandom);
    cycle();
    retire();
    new_req(1); ruse[1] = 1; raddr[1] = 4'd11;
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_cmp++;
      if (obs_ready !== 2'b00 || wb_valid !== 1'b1 || wb_rw_addr !== 4'd5) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got ready=%b v=%b a=%h want ready=00 v=1 a=5", k, obs_ready, wb_valid, wb_rw_addr);
      end
    end
    wb_stall = 1'b0;
    cycle();
    n_cmp++;
    if (obs_ready !== 2'b10 || wb_rw_addr !== 4'd11 || wb_grant_id !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release: got ready=%b a=%h id=%0d want ready=10 a=b id=1", obs_ready, wb_rw_addr, wb_grant_id);
    end
    retire();
    cycle();
  endtask

  task automatic test_collision();
    int grants [$];
    do_reset();
    idle_all();
    regs_obs[7] = '0; ps_obs = 1'b0;
    rv[0] = 1; ruse[0] = 1; raddr[0] = 4'd7; rdata[0] = DW'(1);
    rv[1] = 1; ruse[1] = 1; raddr[1] = 4'd7; rdata[1] = DW'(2); rwps[1] = 1; rps[1] = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (last_grant >= 0) grants.push_back(last_grant);
      retire();
    end
    n_cmp++;
    if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin
      n_bad++;
      $display("FAIL collision_order: got %p want '{0,1}", grants);
    end
    n_cmp++;
    if (regs_obs[7] !== DW'(2) || ps_obs !== 1'b1) begin
      n_bad++;
      $display("FAIL collision_final: got r7=%h ps=%b want r7=2 ps=1", regs_obs[7], ps_obs);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    idle_all();
    rv[1] = 1; ruse[1] = 1; raddr[1] = 4'd9; rdata[1] = DW'(8'h3C);
    cycle();
`ifdef RF_WB_BYPASS_EN
    n_cmp++;
    if (obs_byp_valid !== 1'b1 || obs_byp_addr !== 4'd9 || obs_byp_data !== DW'(8'h3C)) begin
      n_bad++;
      $display("FAIL bypass_early: got v=%b a=%h d=%h want v=1 a=9 d=3c", obs_byp_valid, obs_byp_addr, obs_byp_data);
    end
`endif
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_rw_addr !== 4'd9 || wb_data !== DW'(8'h3C) || wb_grant_id !== 1'b1) begin
      n_bad++;
      $display("FAIL bypass_wb: got v=%b a=%h d=%h id=%0d want v=1 a=9 d=3c id=1", wb_valid, wb_rw_addr, wb_data, wb_grant_id);
    end
    retire();
    cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle_all();
    new_req(0);
    cycle();
    retire();
    new_req(0); new_req(1);
    wb_stall = 1'b1;
    cycle();
    n_rst = 1'b0;
    cycle();
    n_rst = 1'b1;
    wb_stall = 1'b0;
    cycle();
    n_cmp++;
    if (obs_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_mid_rearb: got %b want 01", obs_ready);
    end
    retire();
    idle_all();
    cycle();
  endtask

  task automatic test_random();
    do_reset();
    idle_all();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NR; i++) if (!rv[i] && $urandom_range(0, 1) != 0) new_req(i);
      wb_stall = ($urandom_range(0, 3) == 0);
      n_rst = (k % 137 == 136) ? 1'b0 : 1'b1;
      cycle();
      retire();
    end
    n_rst = 1'b1;
    wb_stall = 1'b0;
    idle_all();
    cycle();
  endtask

  initial begin
    n_rst = 1'b0;
    wb_stall = 1'b0;
    idle_all();
    for (int r = 0; r < 16; r++) regs_obs[r] = '0;
    ps_obs = 1'b0;
    m_valid = 0; m_use = 0; m_wps = 0; m_ps = 0; m_addr = '0; m_data = '0; m_gid = 0; m_ptr = 0;
    drive();
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_collision();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
